// File: rtl/pipe_lsu.sv
// rtl/pipe_lsu.sv - MEM-stage load/store unit driving a ready-handshaked data bus
// Stalls the pipeline for each access, traps misaligned requests and aborts on bus timeout.
module pipe_lsu #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT     = 255,
  parameter bit ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [2:0]        req_dmtype,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);
  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int BW    = 2 * LANES;
  localparam int CW    = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic              we_q, err_q;
  logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
  logic [LANES-1:0]  be_q;
  logic [2:0]        type_q;
  logic [OFFW-1:0]   off_q;

  logic [2:0]        req_type;
  logic [3:0]        req_size;
  logic [OFFW-1:0]   req_off;
  logic              req_mis;
  logic [BW-1:0]     be_wide;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   shifted, ld_data;
  logic              accept, tmo_hit;

  // Dword and unsigned-word encodings only exist on RV64; 111 is treated as a word.
  always_comb begin
    req_type = req_dmtype;
    if (req_dmtype == 3'b111 || (XLEN == 32 && (req_dmtype == 3'b101 || req_dmtype == 3'b110)))
      req_type = 3'b000;
    case (req_type)
      3'b001, 3'b010: req_size = 4'd2;
      3'b011, 3'b100: req_size = 4'd1;
      3'b101:         req_size = 4'd8;
      default:        req_size = 4'd4;
    endcase
    req_off = req_addr[OFFW-1:0];
    req_mis = ALIGN_CHECK && ((req_off & OFFW'(req_size - 4'd1)) != '0);
    be_wide = ((BW'(1) << req_size) - BW'(1)) << req_off;
    case (req_size)
      4'd1:    wdata_rep = {LANES{req_wdata[7:0]}};
      4'd2:    wdata_rep = {(LANES/2){req_wdata[15:0]}};
      4'd4:    wdata_rep = {(LANES/4){req_wdata[31:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (type_q)
      3'b001:  begin ld_data = {XLEN{shifted[15]}}; ld_data[15:0] = shifted[15:0]; end
      3'b010:  begin ld_data = '0;                  ld_data[15:0] = shifted[15:0]; end
      3'b011:  begin ld_data = {XLEN{shifted[7]}};  ld_data[7:0]  = shifted[7:0];  end
      3'b100:  begin ld_data = '0;                  ld_data[7:0]  = shifted[7:0];  end
      3'b101:  ld_data = shifted;
      3'b110:  begin ld_data = '0;                  ld_data[31:0] = shifted[31:0]; end
      default: begin ld_data = {XLEN{shifted[31]}}; ld_data[31:0] = shifted[31:0]; end
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // rst also gates the IDLE decode so stall/misalign fall to 0 the moment reset asserts.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    stall    = 1'b0;
    misalign = 1'b0;
    case (state)
      IDLE: begin
        if (rst && req_valid) begin
          if (req_mis) begin
            misalign = 1'b1;
          end else begin
            stall    = 1'b1;
            accept   = 1'b1;
            state_nx = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ready || tmo_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      type_q  <= 3'b000;
      off_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      cnt     <= '0;
      we_q    <= req_we;
      addr_q  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
      be_q    <= be_wide[LANES-1:0];
      wdata_q <= wdata_rep;
      type_q  <= req_type;
      off_q   <= req_off;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      if (mem_ready) begin
        rdata_q <= we_q ? '0 : ld_data;
      end else begin
        cnt <= cnt + CW'(1);
        if (tmo_hit) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign mem_req    = (state == ACCESS);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = mem_req ? addr_q  : '0;
  assign mem_be     = mem_req ? be_q    : '0;
  assign mem_wdata  = mem_req ? wdata_q : '0;
  assign resp_valid = (state == DONE);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_pipe_lsu.sv
// tb/tb_pipe_lsu.sv - randomized self-checking bench for pipe_lsu against a behavioural model
// Three instances: 32-bit TIMEOUT=4, 32-bit unchecked alignment without timeout, 64-bit default.
module tb_pipe_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  sel;
  logic        req_valid, req_we, mem_ready;
  logic [63:0] req_addr, req_wdata, mem_rdata;
  logic [2:0]  req_dmtype;
  int checks = 0;
  int failures = 0;

  logic        d0_stall, d0_rv, d0_err, d0_mis, d0_req, d0_we;
  logic [31:0] d0_rdata, d0_addr, d0_wdata;
  logic [3:0]  d0_be;
  logic        d1_stall, d1_rv, d1_err, d1_mis, d1_req, d1_we;
  logic [31:0] d1_rdata, d1_addr, d1_wdata;
  logic [3:0]  d1_be;
  logic        d2_stall, d2_rv, d2_err, d2_mis, d2_req, d2_we;
  logic [63:0] d2_rdata, d2_addr, d2_wdata;
  logic [7:0]  d2_be;

  pipe_lsu #(.XLEN(32), .TIMEOUT(4), .ALIGN_CHECK(1)) u_d0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2'd0), .req_we(req_we),
    .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]), .req_dmtype(req_dmtype),
    .stall(d0_stall), .resp_valid(d0_rv), .resp_rdata(d0_rdata), .resp_err(d0_err),
    .misalign(d0_mis), .mem_req(d0_req), .mem_we(d0_we), .mem_addr(d0_addr), .mem_be(d0_be),
    .mem_wdata(d0_wdata), .mem_rdata(mem_rdata[31:0]), .mem_ready(mem_ready && sel == 2'd0));

  pipe_lsu #(.XLEN(32), .TIMEOUT(0), .ALIGN_CHECK(0)) u_d1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2'd1), .req_we(req_we),
    .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]), .req_dmtype(req_dmtype),
    .stall(d1_stall), .resp_valid(d1_rv), .resp_rdata(d1_rdata), .resp_err(d1_err),
    .misalign(d1_mis), .mem_req(d1_req), .mem_we(d1_we), .mem_addr(d1_addr), .mem_be(d1_be),
    .mem_wdata(d1_wdata), .mem_rdata(mem_rdata[31:0]), .mem_ready(mem_ready && sel == 2'd1));

  pipe_lsu #(.XLEN(64), .TIMEOUT(255), .ALIGN_CHECK(1)) u_d2 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2'd2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_dmtype(req_dmtype),
    .stall(d2_stall), .resp_valid(d2_rv), .resp_rdata(d2_rdata), .resp_err(d2_err),
    .misalign(d2_mis), .mem_req(d2_req), .mem_we(d2_we), .mem_addr(d2_addr), .mem_be(d2_be),
    .mem_wdata(d2_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready && sel == 2'd2));

  logic        o_stall, o_rv, o_err, o_mis, o_req, o_we;
  logic [63:0] o_rdata, o_addr, o_wdata;
  logic [7:0]  o_be;

  always_comb begin
    {o_stall, o_rv, o_err, o_mis, o_req, o_we} = {d2_stall, d2_rv, d2_err, d2_mis, d2_req, d2_we};
    {o_rdata, o_addr, o_wdata, o_be} = {d2_rdata, d2_addr, d2_wdata, d2_be};
    if (sel == 2'd0) begin
      {o_stall, o_rv, o_err, o_mis, o_req, o_we} = {d0_stall, d0_rv, d0_err, d0_mis, d0_req, d0_we};
      {o_rdata, o_addr, o_wdata, o_be} = {32'd0, d0_rdata, 32'd0, d0_addr, 32'd0, d0_wdata, 4'd0, d0_be};
    end else if (sel == 2'd1) begin
      {o_stall, o_rv, o_err, o_mis, o_req, o_we} = {d1_stall, d1_rv, d1_err, d1_mis, d1_req, d1_we};
      {o_rdata, o_addr, o_wdata, o_be} = {32'd0, d1_rdata, 32'd0, d1_addr, 32'd0, d1_wdata, 4'd0, d1_be};
    end
  end

  function automatic int size_of(int xlen, logic [2:0] t);
    case (t)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      3'd5:       return (xlen == 64) ? 8 : 4;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [63:0] exp_load(int xlen, logic [2:0] t, int off, logic [63:0] rd);
    int n;
    bit sgn;
    logic [63:0] v, m;
    n   = size_of(xlen, t);
    sgn = !(t == 3'd2 || t == 3'd4 || (t == 3'd6 && xlen == 64));
    v   = rd >> (8 * off);
    m   = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    v   = v & m;
    if (sgn && n < 8 && v[8*n-1]) v = v | ~m;
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // One full transaction on instance s; ready arrives after waitc wait cycles.
  task automatic do_req(input int s, input logic we, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [2:0] t, input logic [63:0] rd, input int waitc, input string nm);
    int xlen, lanes, off, size, to, n_acc;
    bit mis, err;
    logic [63:0] xmask, e_addr, e_wdata, e_rdata;
    logic [7:0] e_be;
    xlen  = (s == 2) ? 64 : 32;
    to    = (s == 0) ? 4 : (s == 1) ? 0 : 255;
    lanes = xlen / 8;
    xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    addr  = addr & xmask;
    wd    = wd & xmask;
    rd    = rd & xmask;
    off   = int'(addr % 64'(lanes));
    size  = size_of(xlen, t);
    mis   = (s != 1) && (off % size != 0);
    e_addr = addr - 64'(off);
    e_be = '0;
    e_wdata = '0;
    for (int i = 0; i < lanes; i++) begin
      if (i >= off && i < off + size) e_be[i] = 1'b1;
      e_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    err     = (to != 0) && (waitc >= to);
    n_acc   = err ? to : waitc + 1;
    e_rdata = (we || err) ? 64'd0 : exp_load(xlen, t, off, rd);

    @(posedge clk); #1;
    sel = 2'(s); req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_dmtype = t; mem_ready = 1'b0; mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    checks++;
    if ({o_mis, o_stall, o_req, o_rv} !== (mis ? 4'b1000 : 4'b0100)) begin
      failures++;
      $display("FAIL %s request cycle mis/stall/req/rv got %b want %b", nm,
               {o_mis, o_stall, o_req, o_rv}, mis ? 4'b1000 : 4'b0100);
    end
    if (mis) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_stall, o_req, o_mis, o_rv} !== 4'b0000) begin
        failures++;
        $display("FAIL %s after trap stall/req/mis/rv got %b want 0000", nm, {o_stall, o_req, o_mis, o_rv});
      end
      return;
    end
    for (int i = 0; i < n_acc; i++) begin
      @(posedge clk); #1;
      mem_ready = (i == waitc);
      mem_rdata = (i == waitc) ? rd : {$urandom, $urandom};
      req_addr  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({o_req, o_stall, o_rv, o_mis} !== 4'b1100) begin
        failures++;
        $display("FAIL %s access %0d req/stall/rv/mis got %b want 1100", nm, i, {o_req, o_stall, o_rv, o_mis});
      end
      checks++;
      if ({o_we, o_addr, o_be} !== {we, e_addr, e_be}) begin
        failures++;
        $display("FAIL %s access %0d we/addr/be got %b/%h/%b want %b/%h/%b", nm, i,
                 o_we, o_addr, o_be, we, e_addr, e_be);
      end
      if (we) begin
        checks++;
        if (o_wdata !== e_wdata) begin
          failures++;
          $display("FAIL %s access %0d wdata got %h want %h", nm, i, o_wdata, e_wdata);
        end
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    checks++;
    if ({o_rv, o_err, o_stall, o_req} !== {1'b1, err, 2'b00}) begin
      failures++;
      $display("FAIL %s done rv/err/stall/req got %b want %b", nm, {o_rv, o_err, o_stall, o_req}, {1'b1, err, 2'b00});
    end
    checks++;
    if (o_rdata !== e_rdata) begin
      failures++;
      $display("FAIL %s done rdata got %h want %h", nm, o_rdata, e_rdata);
    end
  endtask

  task automatic test_idle(input string nm);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_stall, o_mis, o_req, o_rv, o_err, o_we, o_rdata, o_addr, o_be, o_wdata} !== '0) begin
      failures++;
      $display("FAIL %s idle outputs got stall=%b req=%b rv=%b rdata=%h addr=%h be=%b want all 0",
               nm, o_stall, o_req, o_rv, o_rdata, o_addr, o_be);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sel = 2'd0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_dmtype = 3'd0; mem_ready = 1'b0; mem_rdata = '0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if ({o_stall, o_mis, o_req, o_rv, o_err, o_we, o_rdata, o_addr, o_be, o_wdata} !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got stall=%b req=%b rv=%b want all 0", s, o_stall, o_req, o_rv);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sel = 2'd0;
  endtask

  task automatic test_plan_cases();
    do_req(0, 1'b0, 64'h13, 64'h0, 3'b011, 64'h80FF_1234, 0, "lb_0x13");
    do_req(0, 1'b0, 64'h13, 64'h0, 3'b100, 64'h80FF_1234, 0, "lbu_0x13");
    do_req(0, 1'b1, 64'h22, 64'h0000_BEEF, 3'b001, 64'h0, 3, "sh_0x22");
    do_req(0, 1'b0, 64'h06, 64'h0, 3'b000, 64'h0, 0, "lw_mis_trap");
    test_idle("after_trap");
    do_req(1, 1'b0, 64'h06, 64'h0, 3'b000, 64'h1122_3344, 1, "lw_mis_nocheck");
    do_req(1, 1'b0, 64'h08, 64'h0, 3'b000, 64'hCAFE_F00D, 300, "lw_long_wait_no_timeout");
    do_req(2, 1'b0, 64'h104, 64'h0, 3'b110, 64'h8765_4321_0000_0000, 0, "lwu_0x104");
    do_req(2, 1'b1, 64'h108, 64'h0123_4567_89AB_CDEF, 3'b101, 64'h0, 2, "sd_0x108");
    do_req(2, 1'b0, 64'h10E, 64'h0, 3'b001, 64'h8001_0000_0000_0000, 1, "lh_0x10e");
    test_idle("after_plan");
  endtask

  task automatic test_timeout();
    do_req(0, 1'b0, 64'h40, 64'h0, 3'b000, 64'hDEAD_BEEF, 20, "timeout");
    test_idle("after_timeout");
    do_req(0, 1'b0, 64'h44, 64'h0, 3'b000, 64'h1234_5678, 3, "after_timeout_load");
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    sel = 2'd0; req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h80; req_dmtype = 3'd0; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checks++;
    if ({o_req, o_stall} !== 2'b11) begin
      failures++;
      $display("FAIL async_reset_pre req/stall got %b want 11", {o_req, o_stall});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({o_stall, o_mis, o_req, o_rv, o_err, o_we, o_rdata, o_addr, o_be, o_wdata} !== '0) begin
      failures++;
      $display("FAIL async_reset outputs got stall=%b req=%b be=%b addr=%h want all 0", o_stall, o_req, o_be, o_addr);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    test_idle("after_async_reset");
    do_req(0, 1'b0, 64'h82, 64'h0, 3'b001, 64'h7FFF_0000, 1, "load_after_reset");
  endtask

  task automatic test_random();
    int s, size;
    logic [2:0] t;
    logic [63:0] addr;
    for (int n = 0; n < 80; n++) begin
      s    = $urandom_range(0, 2);
      t    = 3'($urandom_range(0, 7));
      size = size_of((s == 2) ? 64 : 32, t);
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(size - 1);
      do_req(s, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, t, {$urandom, $urandom},
             $urandom_range(0, 6), "random");
      if ($urandom_range(0, 2) == 0) test_idle("random_gap");
    end
  endtask

  task automatic test_back_to_back();
    do_req(2, 1'b1, 64'h200, 64'hA5, 3'b011, 64'h0, 0, "b2b_sb");
    do_req(2, 1'b0, 64'h203, 64'h0, 3'b011, 64'h0000_0000_FE00_0000, 0, "b2b_lb");
    do_req(2, 1'b0, 64'h204, 64'h0, 3'b000, 64'h8000_0000_0000_0000, 0, "b2b_lw_neg");
    test_idle("after_b2b");
  endtask

  initial begin
    test_reset();
    test_plan_cases();
    test_timeout();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_lsu.md
Name: pipe_lsu

Overview:
MEM-stage load/store unit for the pipelined RISC-V core, parametrised in data width (XLEN 32/64). It replaces the direct wiring of Addr_out, Data_out and DMType. It drives a ready-handshaked data bus, generates byte enables and write-lane replication, and sign- or zero-extends load data. It stalls the pipeline until the bus answers, detects misaligned accesses, and aborts on a bus timeout.

Parameters:
XLEN, 32, datapath and address width; legal values are 32 and 64.
TIMEOUT, 255, maximum number of ACCESS cycles without mem_ready before abort; 0 disables the timeout.
ALIGN_CHECK, 1, 1 means misaligned requests are trapped; 0 means no check is made.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  the MEM-stage instruction accesses memory (load or store).
req_we  in  1  1 for a store, 0 for a load.
req_addr  in  XLEN  effective address (EX_MEM ALU result).
req_wdata  in  XLEN  store data (forwarded rs2).
req_dmtype  in  3  DMType encoding: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned, 101 dword (XLEN=64 only), 110 word unsigned (XLEN=64 only).
stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  XLEN  extended load data; 0 for stores and on error.
resp_err  out  1  qualifies resp_valid; set on timeout.
misalign  out  1  one-cycle trap pulse; no bus access is made.
mem_req  out  1  bus request.
mem_we  out  1  bus write.
mem_addr  out  XLEN  lane-aligned address (low log2(XLEN/8) bits cleared).
mem_be  out  XLEN/8  byte enables.
mem_wdata  out  XLEN  lane-replicated write data.
mem_rdata  in  XLEN  bus read data.
mem_ready  in  1  bus completion (MIO_ready).

Behaviour:
- Definitions: LANES = XLEN/8; off = req_addr[log2(LANES)-1:0]; size = 1, 2, 4 or 8 bytes from dmtype.
- On XLEN=32, encodings 101 and 110 behave as 000. Encoding 111 behaves as 000.
- Reset (rst low, async): state IDLE, counter 0. All outputs are 0 immediately, including mem_req while in ACCESS; the in-flight access is abandoned.
- Misaligned means ALIGN_CHECK=1 and off mod size != 0.

State machine, states IDLE, ACCESS, DONE:
- IDLE, req_valid && misaligned: misalign=1 in that cycle (combinational), stall=0, no state change. The trap logic flushes the instruction.
- IDLE, req_valid && !misaligned: stall=1 (combinational). Register mem_we, mem_addr, mem_be, mem_wdata, dmtype and off. Clear the counter. Go to ACCESS.
- ACCESS: mem_req=1, stall=1, and the bus outputs stay stable.
  - mem_ready=1: capture extended data, go to DONE.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without ready, go to DONE with the error flag set and rdata 0.
- DONE: mem_req=0, stall=0, resp_valid=1, resp_err=error flag. req_* inputs are ignored this cycle (they are still the held instruction). Go to IDLE.
- Latency: request seen in cycle 0, ready in cycle k≥1, then stall is high in cycles 0..k and resp_valid is high in cycle k+1. Minimum stall is 2 cycles.

Bus-side data rules:
- Byte enables: mem_be = ((1<<size)-1) << off, truncated to LANES bits. With ALIGN_CHECK=0, bits shifted out are dropped.
- Write data: mem_wdata replicates the byte, half or word across all lanes; word/dword stores pass through.
- Load data: r = mem_rdata >> (8*off), then
  - 000: sign-extend r[31:0]; on XLEN=32 this is pass-through.
  - 110: zero-extend r[31:0].
  - 001 / 010: sign- / zero-extend r[15:0].
  - 011 / 100: sign- / zero-extend r[7:0].
  - 101: r unchanged.
- resp_rdata holds its value until the next DONE, then returns to 0 in IDLE. resp_valid is never asserted outside DONE.
- mem_ready outside ACCESS is ignored.
- req_valid deasserting during ACCESS is ignored; only reset aborts an access.

Test Plan:
- XLEN=32; load byte, addr 0x13, rdata 0x80FF_1234, ready in cycle 1 -> mem_be=4'b1000, mem_addr=0x10, stall high for 2 cycles, resp_valid at cycle 2 with rdata 0xFFFF_FF80. Repeat with 100 -> 0x0000_0080.
- Store half, addr 0x22, wdata 0x0000_BEEF, ready after 3 wait cycles -> mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, stall high for 5 cycles, mem_req stable throughout, resp_rdata=0.
- Load word at 0x06 with ALIGN_CHECK=1 -> misalign pulse in the same cycle, mem_req never rises, stall=0. Same request with ALIGN_CHECK=0 -> access proceeds with mem_be=4'b1100.
- TIMEOUT=4, mem_ready held 0 -> mem_req high for 4 cycles, then resp_valid=1, resp_err=1, rdata=0; the next request works normally.
- rst pulsed low in the 2nd ACCESS cycle -> mem_req and stall drop asynchronously. After release: IDLE, all outputs 0, and a new load completes correctly.
- XLEN=64; load 110 at 0x104, rdata 0x8765_4321_0000_0000 -> mem_be=8'hF0, result 0x0000_0000_8765_4321. Dword store at 0x108 -> mem_be=8'hFF.
